// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load/clear, wrap-or-saturate and event flags
// Optional snapshot capture port enabled by UPDOWN_COUNTER_SNAPSHOT_EN.
module updown_counter_param #(
   parameter int unsigned             WIDTH     = 16,
   parameter logic [WIDTH-1:0]        MAX_COUNT = {WIDTH{1'b1}},
   parameter bit                      SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             overflow
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
   ,
   input  logic             snap,
   output logic [WIDTH-1:0] snap_count,
   output logic             snap_valid
`endif
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             overflow_q, overflow_d;
   logic             at_max, at_zero;

   assign at_max  = (count_q == MAX_COUNT);
   assign at_zero = (count_q == '0);

   always_comb begin
      count_d    = count_q;
      wrap_d     = 1'b0;
      overflow_d = overflow_q;
      if (clear) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (load) begin
         count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
      end else if (enable) begin
         if (up_dn) begin
            if (at_max) begin
               count_d    = SATURATE ? MAX_COUNT : '0;
               wrap_d     = 1'b1;
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (at_zero) begin
               count_d    = SATURATE ? '0 : MAX_COUNT;
               wrap_d     = 1'b1;
               overflow_d = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         overflow_q <= overflow_d;
      end
   end

   assign count    = count_q;
   assign wrap     = wrap_q;
   assign overflow = overflow_q;
   assign tc       = enable & ((up_dn & at_max) | (~up_dn & at_zero));

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
   logic [WIDTH-1:0] snap_count_q, snap_count_d;
   logic             snap_valid_q;

   // Captures the pre-update count regardless of clear/load on the same edge.
   assign snap_count_d = snap ? count_q : snap_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_count_q <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         snap_count_q <= snap_count_d;
         snap_valid_q <= snap;
      end
   end

   assign snap_count = snap_count_q;
   assign snap_valid = snap_valid_q;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - directed vector bench for updown_counter_param (wrap and saturate instances)
module tb_updown_counter_param;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic         enable = 1'b0;
   logic         up_dn = 1'b1;

   logic [W-1:0] count_w, count_s;
   logic         tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
   logic         snap = 1'b0;
   logic [W-1:0] snap_count_w, snap_count_s;
   logic         snap_valid_w, snap_valid_s;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(W), .MAX_COUNT(8'd9), .SATURATE(1'b0)) dut_w (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
      .enable(enable), .up_dn(up_dn), .count(count_w), .tc(tc_w), .wrap(wrap_w),
      .overflow(ovf_w)
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
      , .snap(snap), .snap_count(snap_count_w), .snap_valid(snap_valid_w)
`endif
   );

   updown_counter_param #(.WIDTH(W), .MAX_COUNT(8'd9), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
      .enable(enable), .up_dn(up_dn), .count(count_s), .tc(tc_s), .wrap(wrap_s),
      .overflow(ovf_s)
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
      , .snap(snap), .snap_count(snap_count_s), .snap_valid(snap_valid_s)
`endif
   );

   typedef struct {
      logic         clr;
      logic         ld;
      logic [W-1:0] lv;
      logic         en;
      logic         up;
      logic         tc;
      logic [W-1:0] cnt;
      logic         wr;
      logic         ov;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(input logic clr, input logic ld, input logic [W-1:0] lv,
                               input logic en, input logic up, input logic tcx,
                               input logic [W-1:0] cnt, input logic wr, input logic ov);
      vec_t v;
      v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.up = up;
      v.tc = tcx; v.cnt = cnt; v.wr = wr; v.ov = ov;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input logic clr, input logic ld, input logic [W-1:0] lv,
                        input logic en, input logic up);
      @(negedge clk);
      clear = clr; load = ld; load_value = lv; enable = en; up_dn = up;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // clr ld lv en up | tc_pre | count wrap ovf  (wrap instance, MAX_COUNT=9)
      tbl[0]  = mk(0,0,  0,1,1, 0, 1,0,0);
      tbl[1]  = mk(0,0,  0,1,1, 0, 2,0,0);
      tbl[2]  = mk(0,0,  0,1,1, 0, 3,0,0);
      tbl[3]  = mk(0,0,  0,1,1, 0, 4,0,0);
      tbl[4]  = mk(0,0,  0,1,1, 0, 5,0,0);
      tbl[5]  = mk(0,0,  0,1,1, 0, 6,0,0);
      tbl[6]  = mk(0,0,  0,1,1, 0, 7,0,0);
      tbl[7]  = mk(0,0,  0,1,1, 0, 8,0,0);
      tbl[8]  = mk(0,0,  0,1,1, 0, 9,0,0);
      tbl[9]  = mk(0,0,  0,1,1, 1, 0,1,1);
      tbl[10] = mk(0,0,  0,1,1, 0, 1,0,1);
      tbl[11] = mk(0,0,  0,1,1, 0, 2,0,1);
      tbl[12] = mk(0,0,  0,1,0, 0, 1,0,1);
      tbl[13] = mk(0,0,  0,1,0, 0, 0,0,1);
      tbl[14] = mk(0,0,  0,1,0, 1, 9,1,1);
      tbl[15] = mk(0,0,  0,1,0, 0, 8,0,1);
      tbl[16] = mk(0,1,200,1,1, 0, 9,0,1);
      tbl[17] = mk(0,0,  0,0,1, 0, 9,0,1);
      tbl[18] = mk(1,1,200,1,1, 1, 0,0,0);
      tbl[19] = mk(0,0,  0,1,0, 1, 9,1,1);
      tbl[20] = mk(0,1,  5,0,0, 0, 5,0,1);
      tbl[21] = mk(1,0,  0,0,0, 0, 0,0,0);
      tbl[22] = mk(0,1,  9,1,0, 1, 9,0,0);
      tbl[23] = mk(0,1,  3,1,1, 1, 3,0,0);

      #1;
      chk("reset_count", count_w, 0);
      chk("reset_wrap", wrap_w, 0);
      chk("reset_ovf", ovf_w, 0);
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
      chk("reset_snap_count", snap_count_w, 0);
      chk("reset_snap_valid", snap_valid_w, 0);
`endif
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         clear = tbl[i].clr; load = tbl[i].ld; load_value = tbl[i].lv;
         enable = tbl[i].en; up_dn = tbl[i].up;
         #1;
         chk($sformatf("v%0d_tc", i), tc_w, tbl[i].tc);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", i), count_w, tbl[i].cnt);
         chk($sformatf("v%0d_wrap", i), wrap_w, tbl[i].wr);
         chk($sformatf("v%0d_ovf", i), ovf_w, tbl[i].ov);
      end

      // Saturating instance: hold at both range ends with repeated wrap pulses.
      drive(1, 0, 0, 0, 1);
      chk("sat_clear_ovf", ovf_s, 0);
      drive(0, 1, 8, 0, 1);
      chk("sat_load8", count_s, 8);
      drive(0, 0, 0, 1, 1);
      chk("sat_up1_count", count_s, 9);
      chk("sat_up1_wrap", wrap_s, 0);
      drive(0, 0, 0, 1, 1);
      chk("sat_up2_count", count_s, 9);
      chk("sat_up2_wrap", wrap_s, 1);
      drive(0, 0, 0, 1, 1);
      chk("sat_up3_count", count_s, 9);
      chk("sat_up3_wrap", wrap_s, 1);
      chk("sat_up3_ovf", ovf_s, 1);
      drive(0, 0, 0, 1, 0);
      chk("sat_dn_count", count_s, 8);
      chk("sat_dn_wrap", wrap_s, 0);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      chk("sat_lo_count", count_s, 0);
      chk("sat_lo_wrap", wrap_s, 1);
      chk("sat_lo_tc", tc_s, 1);

      // Asynchronous reset mid-count at 5, then resume from 1.
      drive(1, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1);
      chk("pre_reset_count", count_w, 5);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_count", count_w, 0);
      chk("async_reset_ovf", ovf_w, 0);
      chk("async_reset_wrap", wrap_w, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("resume_count", count_w, 1);

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
      drive(1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1);
      @(negedge clk);
      snap = 1'b1;
      @(posedge clk);
      #1;
      chk("snap_edge_count", count_w, 5);
      chk("snap_count", snap_count_w, 4);
      chk("snap_valid_1", snap_valid_w, 1);
      @(negedge clk);
      snap = 1'b0;
      @(posedge clk);
      #1;
      chk("snap_valid_0", snap_valid_w, 0);
      chk("snap_count_hold", snap_count_w, 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
